// File: rtl/reg_file_sb.sv
// reg_file_sb: parametrised register file with two combinational read ports,
// one synchronous write port, optional hardwired-zero register 0, same-cycle
// write-to-read bypass and a per-register pending-write scoreboard.
//
// Scoreboard semantics: rg_SBS marks rg_SBA busy (a producer has been issued),
// an effective write clears the busy bit of rg_A3. When both hit the same
// register on one edge the set wins, because the new producer now owns it.
// rg_busy_cnt tracks the population count of the busy vector.
//
// There is no valid/ready handshake: every input is sampled on each rising
// edge of clock, and read outputs are a pure function of the current inputs
// and stored state.
module reg_file_sb #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 5,
  parameter int ZERO_R0     = 1,
  parameter int RESET_INDEX = 1,
  parameter int BYPASS      = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rg_A1,
  input  logic [ADDR_W-1:0] rg_A2,
  input  logic [ADDR_W-1:0] rg_A3,
  input  logic [DATA_W-1:0] rg_WD3,
  input  logic              rg_WE3,
  input  logic              rg_SBS,
  input  logic [ADDR_W-1:0] rg_SBA,
  output logic [DATA_W-1:0] rg_RD1,
  output logic [DATA_W-1:0] rg_RD2,
  output logic              rg_busy1,
  output logic              rg_busy2,
  output logic [ADDR_W:0]   rg_busy_cnt
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [ADDR_W:0]   busy_cnt_q;

  logic wr_eff;
  logic set_eff;
  logic cnt_inc;
  logic cnt_dec;

  // Writes and scoreboard sets aimed at a hardwired-zero register 0 are dropped.
  assign wr_eff  = rg_WE3 && !((ZERO_R0 != 0) && (rg_A3 == '0));
  assign set_eff = rg_SBS && !((ZERO_R0 != 0) && (rg_SBA == '0));

  // Count up when a set newly marks a register busy; count down when a write
  // clears a busy register that is not simultaneously re-claimed by a set.
  assign cnt_inc = set_eff && !busy[rg_SBA];
  assign cnt_dec = wr_eff && busy[rg_A3] && !(set_eff && (rg_SBA == rg_A3));

  // Register array: reset contents, then one synchronous write per edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        if ((RESET_INDEX != 0) && !((ZERO_R0 != 0) && (i == 0))) begin
          regs[i] <= DATA_W'(i);
        end else begin
          regs[i] <= '0;
        end
      end
    end else if (wr_eff) begin
      regs[rg_A3] <= rg_WD3;
    end
  end

  // Busy bits: clear on write, then set; the later assignment lets set win.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy <= '0;
    end else begin
      if (wr_eff) begin
        busy[rg_A3] <= 1'b0;
      end
      if (set_eff) begin
        busy[rg_SBA] <= 1'b1;
      end
    end
  end

  // Busy counter: registered alongside the busy bits, net of one inc and one dec.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy_cnt_q <= '0;
    end else begin
      case ({cnt_inc, cnt_dec})
        2'b10:   busy_cnt_q <= busy_cnt_q + 1'b1;
        2'b01:   busy_cnt_q <= busy_cnt_q - 1'b1;
        default: busy_cnt_q <= busy_cnt_q;
      endcase
    end
  end

  assign rg_busy_cnt = busy_cnt_q;

  // Read port 1: zero register, then same-cycle bypass, then stored state.
  always_comb begin
    rg_RD1   = regs[rg_A1];
    rg_busy1 = busy[rg_A1];
    if ((ZERO_R0 != 0) && (rg_A1 == '0)) begin
      rg_RD1   = '0;
      rg_busy1 = 1'b0;
    end else if ((BYPASS != 0) && wr_eff && (rg_A3 == rg_A1)) begin
      rg_RD1   = rg_WD3;
      rg_busy1 = 1'b0;
    end
  end

  // Read port 2: same priority as port 1.
  always_comb begin
    rg_RD2   = regs[rg_A2];
    rg_busy2 = busy[rg_A2];
    if ((ZERO_R0 != 0) && (rg_A2 == '0)) begin
      rg_RD2   = '0;
      rg_busy2 = 1'b0;
    end else if ((BYPASS != 0) && wr_eff && (rg_A3 == rg_A2)) begin
      rg_RD2   = rg_WD3;
      rg_busy2 = 1'b0;
    end
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: three configurations of reg_file_sb driven from shared
// inputs and compared against a behavioural array/scoreboard model.
//   inst 0: ZERO_R0=1 RESET_INDEX=1 BYPASS=1 (defaults)
//   inst 1: ZERO_R0=1 RESET_INDEX=1 BYPASS=0
//   inst 2: ZERO_R0=0 RESET_INDEX=0 BYPASS=1
module tb_reg_file_sb;

  localparam int NI = 3;
  localparam int OW = 72;

  logic        clock;
  logic        reset;
  logic [4:0]  a1, a2, a3, sba;
  logic [31:0] wd3;
  logic        we3, sbs;

  logic [31:0] rd1   [NI];
  logic [31:0] rd2   [NI];
  logic        busy1 [NI];
  logic        busy2 [NI];
  logic [5:0]  cnt   [NI];

  int p_zero [NI] = '{1, 1, 0};
  int p_ridx [NI] = '{1, 1, 0};
  int p_byp  [NI] = '{1, 0, 1};

  logic [31:0] m_regs [NI][32];
  logic        m_busy [NI][32];

  int n_checks = 0;
  int n_fail   = 0;

  reg_file_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_R0(1), .RESET_INDEX(1), .BYPASS(1)) u_dut0 (
    .clock(clock), .reset(reset), .rg_A1(a1), .rg_A2(a2), .rg_A3(a3), .rg_WD3(wd3),
    .rg_WE3(we3), .rg_SBS(sbs), .rg_SBA(sba), .rg_RD1(rd1[0]), .rg_RD2(rd2[0]),
    .rg_busy1(busy1[0]), .rg_busy2(busy2[0]), .rg_busy_cnt(cnt[0]));

  reg_file_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_R0(1), .RESET_INDEX(1), .BYPASS(0)) u_dut1 (
    .clock(clock), .reset(reset), .rg_A1(a1), .rg_A2(a2), .rg_A3(a3), .rg_WD3(wd3),
    .rg_WE3(we3), .rg_SBS(sbs), .rg_SBA(sba), .rg_RD1(rd1[1]), .rg_RD2(rd2[1]),
    .rg_busy1(busy1[1]), .rg_busy2(busy2[1]), .rg_busy_cnt(cnt[1]));

  reg_file_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_R0(0), .RESET_INDEX(0), .BYPASS(1)) u_dut2 (
    .clock(clock), .reset(reset), .rg_A1(a1), .rg_A2(a2), .rg_A3(a3), .rg_WD3(wd3),
    .rg_WE3(we3), .rg_SBS(sbs), .rg_SBA(sba), .rg_RD1(rd1[2]), .rg_RD2(rd2[2]),
    .rg_busy1(busy1[2]), .rg_busy2(busy2[2]), .rg_busy_cnt(cnt[2]));

  // Clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // ---------------- reference model ----------------
  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      for (int i = 0; i < 32; i++) begin
        m_regs[k][i] = (p_ridx[k] != 0 && !(p_zero[k] != 0 && i == 0)) ? i : 0;
        m_busy[k][i] = 1'b0;
      end
    end
  endtask

  task automatic model_update();
    for (int k = 0; k < NI; k++) begin
      bit weff, seff;
      weff = we3 && !(p_zero[k] != 0 && a3 == 0);
      seff = sbs && !(p_zero[k] != 0 && sba == 0);
      if (weff) begin
        m_regs[k][a3] = wd3;
        m_busy[k][a3] = 1'b0;
      end
      if (seff) m_busy[k][sba] = 1'b1;
    end
  endtask

  function automatic logic [32:0] m_port(int k, logic [4:0] a);
    bit weff;
    weff = we3 && !(p_zero[k] != 0 && a3 == 0);
    if (p_zero[k] != 0 && a == 0) return 33'd0;
    if (p_byp[k] != 0 && weff && a3 == a) return {wd3, 1'b0};
    return {m_regs[k][a], m_busy[k][a]};
  endfunction

  function automatic logic [5:0] m_cnt(int k);
    int c = 0;
    for (int i = 0; i < 32; i++) c += int'(m_busy[k][i]);
    return 6'(c);
  endfunction

  function automatic logic [OW-1:0] exp_vec(int k);
    logic [32:0] p1, p2;
    p1 = m_port(k, a1);
    p2 = m_port(k, a2);
    return {p1[32:1], p2[32:1], p1[0], p2[0], m_cnt(k)};
  endfunction

  function automatic logic [OW-1:0] obs_vec(int k);
    return {rd1[k], rd2[k], busy1[k], busy2[k], cnt[k]};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clock);
    model_update();
    #1;
  endtask

  task automatic idle_inputs();
    we3 = 1'b0; sbs = 1'b0; a3 = '0; sba = '0; wd3 = '0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    a1 = 5'd7; a2 = 5'd31;
    model_reset();
    #3;
    n_checks++;
    if (rd1[0] !== 32'd7 || rd2[0] !== 32'd31) begin
      n_fail++;
      $display("FAIL reset_index_reads: got %h/%h expected 7/31", rd1[0], rd2[0]);
    end
    n_checks++;
    if (rd1[2] !== 32'd0 || rd2[2] !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_zero_reads: got %h/%h expected 0/0", rd1[2], rd2[2]);
    end
    for (int k = 0; k < NI; k++) begin
      n_checks++;
      if (obs_vec(k) !== exp_vec(k)) begin
        n_fail++;
        $display("FAIL reset_state inst%0d: got %h expected %h", k, obs_vec(k), exp_vec(k));
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_bypass();
    we3 = 1'b1; a3 = 5'd5; wd3 = 32'hDEADBEEF; a1 = 5'd5; a2 = 5'd6;
    #2;
    n_checks++;
    if (rd1[0] !== 32'hDEADBEEF || rd1[1] !== 32'd5) begin
      n_fail++;
      $display("FAIL bypass_pre_edge: got %h/%h expected deadbeef/00000005", rd1[0], rd1[1]);
    end
    for (int k = 0; k < NI; k++) begin
      n_checks++;
      if (obs_vec(k) !== exp_vec(k)) begin
        n_fail++;
        $display("FAIL bypass_pre inst%0d: got %h expected %h", k, obs_vec(k), exp_vec(k));
      end
    end
    step();
    idle_inputs();
    #1;
    n_checks++;
    if (rd1[1] !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL write_post_edge: got %h expected deadbeef", rd1[1]);
    end
  endtask

  task automatic test_zero_reg();
    we3 = 1'b1; a3 = 5'd0; wd3 = 32'h1234; sbs = 1'b1; sba = 5'd0; a1 = 5'd0; a2 = 5'd0;
    #2;
    n_checks++;
    if (rd1[0] !== 32'd0 || busy1[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_reg_pre: got %h busy %b expected 0 busy 0", rd1[0], busy1[0]);
    end
    step();
    idle_inputs();
    #1;
    n_checks++;
    if (rd1[0] !== 32'd0 || busy1[0] !== 1'b0 || cnt[0] !== 6'd0) begin
      n_fail++;
      $display("FAIL zero_reg_post: got %h busy %b cnt %0d expected 0 0 0", rd1[0], busy1[0], cnt[0]);
    end
    for (int k = 0; k < NI; k++) begin
      n_checks++;
      if (obs_vec(k) !== exp_vec(k)) begin
        n_fail++;
        $display("FAIL zero_reg inst%0d: got %h expected %h", k, obs_vec(k), exp_vec(k));
      end
    end
  endtask

  task automatic test_scoreboard();
    logic [4:0]  seq [3] = '{5'd3, 5'd9, 5'd3};
    logic [5:0]  want [3] = '{6'd1, 6'd2, 6'd2};
    for (int s = 0; s < 3; s++) begin
      sbs = 1'b1; sba = seq[s];
      step();
      n_checks++;
      if (cnt[0] !== want[s]) begin
        n_fail++;
        $display("FAIL sb_count step%0d: got %0d expected %0d", s, cnt[0], want[s]);
      end
    end
    idle_inputs();
    a1 = 5'd3;
    #1;
    n_checks++;
    if (busy1[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL sb_busy1: got %b expected 1", busy1[0]);
    end
    we3 = 1'b1; a3 = 5'd3; wd3 = 32'h3333;
    #1;
    n_checks++;
    if (busy1[0] !== 1'b0 || busy1[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL sb_clear_pre: got %b/%b expected 0/1", busy1[0], busy1[1]);
    end
    step();
    n_checks++;
    if (cnt[0] !== 6'd1) begin
      n_fail++;
      $display("FAIL sb_clear_cnt: got %0d expected 1", cnt[0]);
    end
    idle_inputs();
  endtask

  task automatic test_set_clear_same();
    sbs = 1'b1; sba = 5'd4; we3 = 1'b1; a3 = 5'd4; wd3 = 32'h44;
    step();
    idle_inputs();
    a1 = 5'd4;
    #1;
    n_checks++;
    if (rd1[0] !== 32'h44 || busy1[0] !== 1'b1 || cnt[0] !== 6'd2) begin
      n_fail++;
      $display("FAIL same_reg_set_wins: got %h busy %b cnt %0d expected 44 1 2", rd1[0], busy1[0], cnt[0]);
    end
    sbs = 1'b1; sba = 5'd6; we3 = 1'b1; a3 = 5'd9; wd3 = 32'h99;
    step();
    n_checks++;
    if (cnt[0] !== 6'd2) begin
      n_fail++;
      $display("FAIL set_and_clear_diff: got %0d expected 2", cnt[0]);
    end
    idle_inputs();
    for (int k = 0; k < NI; k++) begin
      n_checks++;
      if (obs_vec(k) !== exp_vec(k)) begin
        n_fail++;
        $display("FAIL set_clear inst%0d: got %h expected %h", k, obs_vec(k), exp_vec(k));
      end
    end
  endtask

  task automatic test_async_reset();
    for (int r = 1; r <= 3; r++) begin
      sbs = 1'b1; sba = 5'(r);
      step();
    end
    idle_inputs();
    we3 = 1'b1; a3 = 5'd1; wd3 = 32'hAA;
    step();
    idle_inputs();
    a1 = 5'd1; a2 = 5'd2;
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    n_checks++;
    if (cnt[0] !== 6'd0 || rd1[0] !== 32'd1 || busy1[0] !== 1'b0 || busy2[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: cnt %0d rd1 %h busy %b%b expected 0 1 00", cnt[0], rd1[0], busy1[0], busy2[0]);
    end
    for (int k = 0; k < NI; k++) begin
      n_checks++;
      if (obs_vec(k) !== exp_vec(k)) begin
        n_fail++;
        $display("FAIL async_reset inst%0d: got %h expected %h", k, obs_vec(k), exp_vec(k));
      end
    end
    #1;
    reset = 1'b0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      bit narrow;
      narrow = ($urandom_range(0, 1) == 1);
      a1  = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      a2  = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      a3  = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      sba = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      we3 = ($urandom_range(0, 2) != 0);
      sbs = ($urandom_range(0, 2) == 0);
      wd3 = $urandom;
      #2;
      for (int k = 0; k < NI; k++) begin
        n_checks++;
        if (obs_vec(k) !== exp_vec(k)) begin
          n_fail++;
          $display("FAIL random cyc%0d inst%0d: got %h expected %h", n, k, obs_vec(k), exp_vec(k));
        end
      end
      step();
    end
    idle_inputs();
  endtask

  // Sequence and final report
  initial begin
    a1 = '0; a2 = '0;
    test_reset();
    test_bypass();
    test_zero_reg();
    test_scoreboard();
    test_set_clear_same();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
